// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding,
// requester count and grant-index width.
package uart_sched_pkg;
  localparam int NUM_REQ   = 4;
  localparam int GNT_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [GNT_IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester / UART-side bundle of the scheduler. master = requesters and
// UART transmitter, slave = scheduler.
interface uart_tx_sched_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [uart_sched_pkg::NUM_REQ-1:0]            Req;
  logic [uart_sched_pkg::NUM_REQ*DATA_WIDTH-1:0] Req_Data;
  logic [uart_sched_pkg::NUM_REQ-1:0]            Gnt;
  logic                                          Tx_Busy;
  logic                                          Tx_Data_valid;
  logic [DATA_WIDTH-1:0]                         Tx_P_DATA;
  logic                                          Sched_Busy;
  logic [uart_sched_pkg::GNT_IDX_W-1:0]          Last_Gnt_ID;
  logic                                          Wdog_Err;

  modport master (
    output Req, Req_Data, Tx_Busy,
    input  Gnt, Tx_Data_valid, Tx_P_DATA, Sched_Busy, Last_Gnt_ID, Wdog_Err
  );
  modport slave (
    input  Req, Req_Data, Tx_Busy,
    output Gnt, Tx_Data_valid, Tx_P_DATA, Sched_Busy, Last_Gnt_ID, Wdog_Err
  );
endinterface

// File: rtl/uart_tx_sched_rr_arb4.sv
// Combinational 4-way round-robin picker. Search starts one past the
// pointer and wraps, so the pointer itself has lowest priority.
module rr_arb4
  import uart_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [GNT_IDX_W-1:0] ptr,
  output logic                 valid,
  output logic [GNT_IDX_W-1:0] index
);
  logic [GNT_IDX_W-1:0] cand;

  // Walk from farthest to nearest candidate so the nearest one wins.
  always_comb begin
    valid = |req;
    index = ptr;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + GNT_IDX_W'(k);
      if (req[cand]) index = cand;
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding a single UART transmitter from 4
// requesters. Optional WAIT_ACK watchdog: define UART_TX_SCHED_WDOG_EN.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int WDOG_CYCLES = 16
) (
  input logic            CLK,
  input logic            Reset,
  uart_tx_sched_if.slave bus
);
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  txv_q, txv_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [GNT_IDX_W-1:0]  last_q, last_d;
  logic                  sbusy_q, sbusy_d;
  logic                  arb_vld;
  logic [GNT_IDX_W-1:0]  arb_idx;

`ifdef UART_TX_SCHED_WDOG_EN
  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             werr_q, werr_d;
`endif

  rr_arb4 u_arb (
    .req   (bus.Req),
    .ptr   (last_q),
    .valid (arb_vld),
    .index (arb_idx)
  );

  // Next-state and next-output decode; all outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    txv_d   = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
`ifdef UART_TX_SCHED_WDOG_EN
    cnt_d   = cnt_q;
    werr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A leftover Tx_Busy blocks issue even with pending requests.
        if (arb_vld && !bus.Tx_Busy) begin
          state_d = ISSUE;
          gnt_d   = idx2oh(arb_idx);
          txv_d   = 1'b1;
          data_d  = bus.Req_Data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          last_d  = arb_idx;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
`ifdef UART_TX_SCHED_WDOG_EN
        cnt_d   = '0;
`endif
      end
      WAIT_ACK: begin
        if (bus.Tx_Busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_TX_SCHED_WDOG_EN
        else if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
          state_d = IDLE;
          werr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.Tx_Busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sbusy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      txv_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= GNT_IDX_W'(NUM_REQ - 1);
      sbusy_q <= 1'b0;
`ifdef UART_TX_SCHED_WDOG_EN
      cnt_q   <= '0;
      werr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      txv_q   <= txv_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sbusy_q <= sbusy_d;
`ifdef UART_TX_SCHED_WDOG_EN
      cnt_q   <= cnt_d;
      werr_q  <= werr_d;
`endif
    end
  end

  assign bus.Gnt           = gnt_q;
  assign bus.Tx_Data_valid = txv_q;
  assign bus.Tx_P_DATA     = data_q;
  assign bus.Last_Gnt_ID   = last_q;
  assign bus.Sched_Busy    = sbusy_q;
`ifdef UART_TX_SCHED_WDOG_EN
  assign bus.Wdog_Err      = werr_q;
`else
  assign bus.Wdog_Err      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: arbitration table plus hand-written
// multi-cycle sequences (busy hold-off, withdrawal, watchdog, reset abort).
module tb_uart_tx_sched;
  logic CLK = 1'b0;
  logic Reset;
  logic busy_drv, busy_mdl, uart_en;
  logic [3:0] bcnt;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, fall_cyc = -1;
  logic prev_busy = 1'b0;
  bit inv_en = 1'b0;

  localparam logic [31:0] DA = 32'h332211A5;
  localparam logic [31:0] DB = 32'h9C7E5D4B;

  uart_tx_sched_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_sched #(.DATA_WIDTH(8), .WDOG_CYCLES(16)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.Tx_Busy = uart_en ? busy_mdl : busy_drv;

  // UART model: busy rises the cycle after the strobe, stays high 10 cycles.
  always @(posedge CLK) begin
    if (!uart_en) begin
      busy_mdl <= 1'b0;
      bcnt     <= 4'd0;
    end else if (bus.Tx_Data_valid) begin
      busy_mdl <= 1'b1;
      bcnt     <= 4'd9;
    end else if (bcnt != 4'd0) begin
      bcnt <= bcnt - 4'd1;
    end else begin
      busy_mdl <= 1'b0;
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  exp_byte;
    logic [1:0]  last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next sampling point and check the per-cycle invariants.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (prev_busy && !bus.Tx_Busy) fall_cyc = cyc;
    prev_busy = bus.Tx_Busy;
    if (inv_en) begin
      chk("gnt_onehot0", 32'($onehot0(bus.Gnt)), 32'd1);
      chk("txv_eq_or_gnt", 32'(bus.Tx_Data_valid), 32'(|bus.Gnt));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},   32'(bus.Gnt), 32'd0);
    chk({tag, "_txv"},   32'(bus.Tx_Data_valid), 32'd0);
    chk({tag, "_data"},  32'(bus.Tx_P_DATA), 32'd0);
    chk({tag, "_last"},  32'(bus.Last_Gnt_ID), 32'd3);
    chk({tag, "_sbusy"}, 32'(bus.Sched_Busy), 32'd0);
    chk({tag, "_wdog"},  32'(bus.Wdog_Err), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 60 && bus.Sched_Busy; k++) tick();
    chk({tag, "_idle"}, 32'(bus.Sched_Busy), 32'd0);
  endtask

  // Drive the UART busy pulse by hand to close out an issued frame.
  task automatic finish_frame(input string tag);
    tick();
    chk({tag, "_ack_gnt"}, 32'(bus.Gnt), 32'd0);
    busy_drv = 1'b1;
    tick();
    tick();
    busy_drv = 1'b0;
    tick();
    chk({tag, "_back_idle"}, 32'(bus.Sched_Busy), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'b0001, DA, 4'b0001, 8'hA5, 2'd0};
    vecs[1] = '{4'b0110, DB, 4'b0010, 8'h5D, 2'd1};
    vecs[2] = '{4'b0110, DA, 4'b0100, 8'h22, 2'd2};
    vecs[3] = '{4'b0110, DB, 4'b0010, 8'h5D, 2'd1};
    vecs[4] = '{4'b1000, DA, 4'b1000, 8'h33, 2'd3};
    vecs[5] = '{4'b1001, DB, 4'b0001, 8'h4B, 2'd0};
    vecs[6] = '{4'b1001, DA, 4'b1000, 8'h33, 2'd3};
    vecs[7] = '{4'b1111, DB, 4'b0001, 8'h4B, 2'd0};
    vecs[8] = '{4'b1100, DA, 4'b0100, 8'h22, 2'd2};

    Reset = 1'b1; uart_en = 1'b0; busy_drv = 1'b0;
    bus.Req = 4'b0; bus.Req_Data = 32'h0;
    repeat (3) tick();
    inv_en = 1'b1;
    chk_reset_vals("rst");
    Reset = 1'b0;
    tick();
    chk("post_rst_idle_gnt", 32'(bus.Gnt), 32'd0);

    // Arbitration table: one frame per record, pointer carries over.
    for (int v = 0; v < 9; v++) begin
      bus.Req = vecs[v].req; bus.Req_Data = vecs[v].data;
      tick();
      chk($sformatf("v%0d_gnt", v),   32'(bus.Gnt), 32'(vecs[v].gnt));
      chk($sformatf("v%0d_txv", v),   32'(bus.Tx_Data_valid), 32'd1);
      chk($sformatf("v%0d_data", v),  32'(bus.Tx_P_DATA), 32'(vecs[v].exp_byte));
      chk($sformatf("v%0d_last", v),  32'(bus.Last_Gnt_ID), 32'(vecs[v].last));
      chk($sformatf("v%0d_sbusy", v), 32'(bus.Sched_Busy), 32'd1);
      bus.Req = 4'b0; bus.Req_Data = 32'hDEADBEEF;
      finish_frame($sformatf("v%0d", v));
      chk($sformatf("v%0d_data_hold", v), 32'(bus.Tx_P_DATA), 32'(vecs[v].exp_byte));
    end

    // All four requesting, UART model in the loop: 0,1,2,3,0 with spacing.
    Reset = 1'b1; tick(); Reset = 1'b0;
    uart_en = 1'b1; bus.Req = 4'b1111; bus.Req_Data = DA; fall_cyc = -1;
    for (int g = 0; g < 5; g++) begin
      int k;
      logic [3:0] eg;
      eg = 4'b0001 << (g % 4);
      for (k = 0; k < 40 && !bus.Tx_Data_valid; k++) tick();
      chk($sformatf("rr%0d_strobe", g), 32'(bus.Tx_Data_valid), 32'd1);
      chk($sformatf("rr%0d_gnt", g), 32'(bus.Gnt), 32'(eg));
      if (g > 0) begin
        chk($sformatf("rr%0d_fall_seen", g), 32'(fall_cyc > 0), 32'd1);
        chk($sformatf("rr%0d_spacing_ge2", g), 32'(cyc - fall_cyc >= 2), 32'd1);
      end
      if (g == 4) bus.Req = 4'b0;
      tick();
    end
    wait_idle("rr");
    tick();
    uart_en = 1'b0;

    // Pending request held off by Tx_Busy in IDLE, issued one cycle after it drops.
    busy_drv = 1'b1; bus.Req = 4'b0100; bus.Req_Data = DA;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("holdoff_txv", 32'(bus.Tx_Data_valid), 32'd0);
      chk("holdoff_sbusy", 32'(bus.Sched_Busy), 32'd0);
    end
    busy_drv = 1'b0;
    tick();
    chk("holdoff_gnt", 32'(bus.Gnt), 32'b0100);
    chk("holdoff_data", 32'(bus.Tx_P_DATA), 32'h22);
    bus.Req = 4'b0;
    finish_frame("holdoff");

    // Request withdrawn while blocked: never granted.
    busy_drv = 1'b1; bus.Req = 4'b0001;
    repeat (3) tick();
    bus.Req = 4'b0; busy_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("withdraw_gnt", 32'(bus.Gnt), 32'd0);
      chk("withdraw_sbusy", 32'(bus.Sched_Busy), 32'd0);
      chk("withdraw_wdog", 32'(bus.Wdog_Err), 32'd0);
    end
    chk("withdraw_last", 32'(bus.Last_Gnt_ID), 32'd2);

    // Tx_Busy never rises after issue.
    bus.Req = 4'b0001;
    tick();
    chk("wd_gnt", 32'(bus.Gnt), 32'b0001);
    bus.Req = 4'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("wd_early_err", 32'(bus.Wdog_Err), 32'd0);
      chk("wd_early_sbusy", 32'(bus.Sched_Busy), 32'd1);
    end
`ifdef UART_TX_SCHED_WDOG_EN
    tick();
    chk("wd_err_pulse", 32'(bus.Wdog_Err), 32'd1);
    chk("wd_err_sbusy", 32'(bus.Sched_Busy), 32'd0);
    chk("wd_err_last", 32'(bus.Last_Gnt_ID), 32'd0);
    tick();
    chk("wd_err_once", 32'(bus.Wdog_Err), 32'd0);
    chk("wd_idle", 32'(bus.Sched_Busy), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nowd_err", 32'(bus.Wdog_Err), 32'd0);
      chk("nowd_sbusy", 32'(bus.Sched_Busy), 32'd1);
    end
    busy_drv = 1'b1; tick(); tick(); busy_drv = 1'b0; tick();
    chk("nowd_idle", 32'(bus.Sched_Busy), 32'd0);
`endif

    // Reset in WAIT_DONE with requests pending and Tx_Busy high.
    bus.Req = 4'b0010; bus.Req_Data = DB;
    tick();
    chk("rstmid_gnt", 32'(bus.Gnt), 32'b0010);
    bus.Req = 4'b0;
    tick();
    busy_drv = 1'b1;
    tick();
    chk("rstmid_in_done", 32'(bus.Sched_Busy), 32'd1);
    Reset = 1'b1; bus.Req = 4'b1111; bus.Req_Data = DA;
    tick();
    chk_reset_vals("rstmid");
    Reset = 1'b0; busy_drv = 1'b0;
    tick();
    chk("rstmid_first_gnt", 32'(bus.Gnt), 32'b0001);
    chk("rstmid_first_data", 32'(bus.Tx_P_DATA), 32'hA5);
    chk("rstmid_first_last", 32'(bus.Last_Gnt_ID), 32'd0);
    bus.Req = 4'b0;
    finish_frame("rstmid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit in case a bounded wait is somehow bypassed.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 expected earlier");
    $fatal(1);
  end
endmodule
